// File: rtl/input_feature_module_if.sv
// Control, BRAM read-port and kernel-stream signals of input_feature_module.
// The master modport is the streaming block; the slave modport is everything around it.
interface input_feature_module_if #(
  parameter int WI                 = 8,
  parameter int BRAM_DATA_WIDTH    = 32,
  parameter int BRAM_ADDRESS_WIDTH = 16
);
  logic                          ap_start;
  logic [8:0]                    ifm_w;
  logic [8:0]                    in_ch;
  logic                          ap_done;
  logic                          bram_en;
  logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr;
  logic [BRAM_DATA_WIDTH-1:0]    bram_dout;
  logic [WI-1:0]                 ifm_data;
  logic                          ifm_vld;
  logic                          ifm_rdy;

  modport master (
    input  ap_start, ifm_w, in_ch, bram_dout, ifm_rdy,
    output ap_done, bram_en, bram_addr, ifm_data, ifm_vld
  );

  modport slave (
    output ap_start, ifm_w, in_ch, bram_dout, ifm_rdy,
    input  ap_done, bram_en, bram_addr, ifm_data, ifm_vld
  );
endinterface

// File: rtl/input_feature_module.sv
// Streams a packed feature map (four WI-bit elements per BRAM word) to the kernel,
// one element per handshake, behind a 2-word prefetch FIFO.
module input_feature_module #(
  parameter int WI                 = 8,
  parameter int BRAM_DATA_WIDTH    = 32,
  parameter int BRAM_DATA_DEPTH    = 64*64*64/4,
  parameter int BRAM_ADDRESS_WIDTH = $clog2(BRAM_DATA_DEPTH),
  parameter int MAX_FEATURE_SIZE   = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input_feature_module_if.master bus
);
  localparam int NW = MAX_FEATURE_SIZE - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                        state_r;
  logic [MAX_FEATURE_SIZE-1:0]   num_r;
  logic [MAX_FEATURE_SIZE-1:0]   elem_cnt_r;
  logic [NW-1:0]                 issued_r;
  logic [1:0]                    lane_r;
  logic                          rd_vld_r;
  logic                          bram_en_r;
  logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr_r;
  logic [BRAM_DATA_WIDTH-1:0]    fifo_mem_r [2];
  logic                          wr_ptr_r;
  logic                          rd_ptr_r;
  logic [1:0]                    fifo_cnt_r;
  logic [WI-1:0]                 ifm_data_r;
  logic                          ifm_vld_r;
  logic                          out_last_r;
  logic                          ap_done_r;
  logic                          done_wait_r;

  logic [MAX_FEATURE_SIZE-1:0]   num_start_s;
  logic [NW-1:0]                 words_s;
  logic                          push_s;
  logic                          load_s;
  logic                          pop_s;
  logic                          last_elem_s;
  logic                          issue_s;
  logic                          xfer_last_s;
  logic [1:0]                    fifo_cnt_nxt_s;
  logic [BRAM_DATA_WIDTH-1:0]    head_s;
  logic [WI-1:0]                 lane_data_s;

  // Datapath decisions: element count, FIFO traffic, read issue and output load.
  always_comb begin
    num_start_s    = MAX_FEATURE_SIZE'(bus.ifm_w) * MAX_FEATURE_SIZE'(bus.ifm_w)
                   * MAX_FEATURE_SIZE'(bus.in_ch);
    words_s        = NW'(num_r[MAX_FEATURE_SIZE-1:2]) + NW'(|num_r[1:0]);
    push_s         = rd_vld_r && (state_r == S_RUN);
    load_s         = (state_r == S_RUN) && (fifo_cnt_r != 2'd0)
                   && (!ifm_vld_r || bus.ifm_rdy) && (elem_cnt_r != num_r);
    last_elem_s    = (elem_cnt_r == (num_r - MAX_FEATURE_SIZE'(1)));
    pop_s          = load_s && ((lane_r == 2'd3) || last_elem_s);
    head_s         = fifo_mem_r[rd_ptr_r];
    lane_data_s    = head_s[lane_r*WI +: WI];
    fifo_cnt_nxt_s = fifo_cnt_r + {1'b0, push_s} - {1'b0, pop_s};
    // Words held after this edge plus the read whose data lands next cycle must leave room.
    issue_s        = (state_r == S_RUN) && (issued_r < words_s)
                   && ((fifo_cnt_nxt_s + {1'b0, bram_en_r}) < 2'd2);
    xfer_last_s    = ifm_vld_r && bus.ifm_rdy && out_last_r;
  end

  // Control FSM with registered read port, prefetch FIFO and output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= S_IDLE;
      num_r         <= '0;
      elem_cnt_r    <= '0;
      issued_r      <= '0;
      lane_r        <= 2'd0;
      rd_vld_r      <= 1'b0;
      bram_en_r     <= 1'b0;
      bram_addr_r   <= '0;
      fifo_mem_r[0] <= '0;
      fifo_mem_r[1] <= '0;
      wr_ptr_r      <= 1'b0;
      rd_ptr_r      <= 1'b0;
      fifo_cnt_r    <= 2'd0;
      ifm_data_r    <= '0;
      ifm_vld_r     <= 1'b0;
      out_last_r    <= 1'b0;
      ap_done_r     <= 1'b0;
      done_wait_r   <= 1'b0;
    end else begin
      rd_vld_r <= bram_en_r;
      case (state_r)
        S_IDLE: begin
          bram_en_r <= 1'b0;
          if (bus.ap_start) begin
            num_r      <= num_start_s;
            elem_cnt_r <= '0;
            issued_r   <= '0;
            lane_r     <= 2'd0;
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
            fifo_cnt_r <= 2'd0;
            out_last_r <= 1'b0;
            if (num_start_s == '0) begin
              state_r     <= S_DONE;
              done_wait_r <= 1'b1;
            end else begin
              state_r <= S_RUN;
            end
          end
        end
        S_RUN: begin
          bram_en_r <= issue_s;
          if (issue_s) begin
            bram_addr_r <= issued_r[BRAM_ADDRESS_WIDTH-1:0];
            issued_r    <= issued_r + NW'(1);
          end
          if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= bus.bram_dout;
            wr_ptr_r             <= ~wr_ptr_r;
          end
          if (pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
          end
          fifo_cnt_r <= fifo_cnt_nxt_s;
          if (load_s) begin
            ifm_data_r <= lane_data_s;
            ifm_vld_r  <= 1'b1;
            out_last_r <= last_elem_s;
            elem_cnt_r <= elem_cnt_r + MAX_FEATURE_SIZE'(1);
            lane_r     <= pop_s ? 2'd0 : lane_r + 2'd1;
          end else if (ifm_vld_r && bus.ifm_rdy) begin
            ifm_vld_r <= 1'b0;
          end
          if (xfer_last_s) begin
            state_r   <= S_DONE;
            ap_done_r <= 1'b1;
          end
        end
        S_DONE: begin
          bram_en_r <= 1'b0;
          // A zero-size start idles one extra cycle before its done pulse.
          if (ap_done_r) begin
            ap_done_r <= 1'b0;
            state_r   <= S_IDLE;
          end else if (done_wait_r) begin
            done_wait_r <= 1'b0;
          end else begin
            ap_done_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          bram_en_r <= 1'b0;
          ifm_vld_r <= 1'b0;
          ap_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bram_en   = bram_en_r;
  assign bus.bram_addr = bram_addr_r;
  assign bus.ifm_data  = ifm_data_r;
  assign bus.ifm_vld   = ifm_vld_r;
  assign bus.ap_done   = ap_done_r;
endmodule

// File: tb/tb_input_feature_module.sv
// Directed self-checking bench for input_feature_module with a 1-cycle-latency BRAM model.
module tb_input_feature_module;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  input_feature_module_if #(.WI(8), .BRAM_DATA_WIDTH(32), .BRAM_ADDRESS_WIDTH(16)) bus ();

  input_feature_module dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [16];
  always @(posedge clk) bus.bram_dout <= mem[bus.bram_addr[3:0]];

  // Transfer/read/done logs plus handshake-hold and buffering observations.
  logic [7:0] xq [$];
  int         aq [$];
  int         done_cnt;
  int         hold_viol;
  int         occ_viol;
  logic       prev_stall;
  logic [7:0] prev_data;

  always @(posedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (bus.ifm_vld !== 1'b1 || bus.ifm_data !== prev_data)) hold_viol++;
      prev_stall = bus.ifm_vld && !bus.ifm_rdy;
      prev_data  = bus.ifm_data;
      if (bus.ifm_vld && bus.ifm_rdy) xq.push_back(bus.ifm_data);
      if (bus.bram_en) begin
        aq.push_back(int'(bus.bram_addr));
        if (aq.size() - xq.size() / 4 > 3) occ_viol++;
      end
      if (bus.ap_done) done_cnt++;
    end
  end

  task automatic clear_logs();
    xq.delete();
    aq.delete();
    done_cnt  = 0;
    hold_viol = 0;
    occ_viol  = 0;
  endtask

  // Returns at the falling edge just after the sampling edge E0.
  task automatic start_run(input logic [8:0] w, input logic [8:0] c);
    @(negedge clk);
    bus.ifm_w    = w;
    bus.in_ch    = c;
    bus.ap_start = 1'b1;
    @(negedge clk);
    bus.ap_start = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] outs;
    outs = {bus.bram_en, bus.ifm_vld, bus.ap_done, |bus.bram_addr, |bus.ifm_data};
    checks++;
    if (outs !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs got %05b want 00000", outs);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    outs = {bus.bram_en, bus.ifm_vld, bus.ap_done, |bus.bram_addr, |bus.ifm_data};
    checks++;
    if (outs !== 5'b00000) begin
      errors++;
      $display("FAIL idle_outputs got %05b want 00000", outs);
    end
  endtask

  task automatic test_single_word();
    bit         exp_en   [10] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    bit         exp_vld  [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    bit         exp_done [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic [7:0] exp_data [10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
    mem[0] = 32'h44332211;
    bus.ifm_rdy = 1'b1;
    start_run(9'd2, 9'd1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (bus.bram_en !== exp_en[i] || (exp_en[i] && bus.bram_addr !== 16'd0)) begin
        errors++;
        $display("FAIL single_en[%0d] got en=%0b addr=%0d want en=%0b addr=0", i, bus.bram_en, bus.bram_addr, exp_en[i]);
      end
      checks++;
      if (bus.ifm_vld !== exp_vld[i] || (exp_vld[i] && bus.ifm_data !== exp_data[i])) begin
        errors++;
        $display("FAIL single_out[%0d] got vld=%0b data=%h want vld=%0b data=%h", i, bus.ifm_vld, bus.ifm_data, exp_vld[i], exp_data[i]);
      end
      checks++;
      if (bus.ap_done !== exp_done[i]) begin
        errors++;
        $display("FAIL single_done[%0d] got %0b want %0b", i, bus.ap_done, exp_done[i]);
      end
    end
  endtask

  task automatic test_partial_word();
    logic [7:0] exp [9] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA};
    mem[0] = 32'h04030201;
    mem[1] = 32'h08070605;
    mem[2] = 32'h000000AA;
    mem[3] = 32'hDEADBEEF;
    clear_logs();
    bus.ifm_rdy = 1'b1;
    start_run(9'd3, 9'd1);
    for (int c = 0; c < 200 && done_cnt == 0; c++) @(negedge clk);
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt != 1 || xq.size() != 9) begin
      errors++;
      $display("FAIL partial_count got done=%0d xfers=%0d want done=1 xfers=9", done_cnt, xq.size());
    end
    for (int i = 0; i < 9 && i < xq.size(); i++) begin
      checks++;
      if (xq[i] !== exp[i]) begin
        errors++;
        $display("FAIL partial_elem[%0d] got %h want %h", i, xq[i], exp[i]);
      end
    end
    checks++;
    if (aq.size() != 3 || aq[0] != 0 || aq[1] != 1 || aq[2] != 2) begin
      errors++;
      $display("FAIL partial_reads got %p want '{0,1,2}", aq);
    end
  endtask

  task automatic test_backpressure();
    for (int j = 0; j < 8; j++) begin
      mem[j] = {8'(8'h43 + 4*j), 8'(8'h42 + 4*j), 8'(8'h41 + 4*j), 8'(8'h40 + 4*j)};
    end
    clear_logs();
    bus.ifm_rdy = 1'b0;
    start_run(9'd4, 9'd2);
    for (int c = 0; c < 2000 && done_cnt == 0; c++) begin
      @(negedge clk);
      bus.ifm_rdy = 1'($urandom_range(0, 1));
    end
    bus.ifm_rdy = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt != 1 || xq.size() != 32) begin
      errors++;
      $display("FAIL bp_count got done=%0d xfers=%0d want done=1 xfers=32", done_cnt, xq.size());
    end
    for (int i = 0; i < xq.size() && i < 32; i++) begin
      checks++;
      if (xq[i] !== 8'(8'h40 + i)) begin
        errors++;
        $display("FAIL bp_elem[%0d] got %h want %h", i, xq[i], 8'(8'h40 + i));
      end
    end
    checks++;
    if (aq.size() != 8 || aq[0] != 0 || aq[7] != 7) begin
      errors++;
      $display("FAIL bp_reads got %p want 0..7", aq);
    end
    checks++;
    if (hold_viol != 0 || occ_viol != 0) begin
      errors++;
      $display("FAIL bp_hold got hold_viol=%0d occ_viol=%0d want 0 0", hold_viol, occ_viol);
    end
  endtask

  task automatic test_zero_size();
    bit exp_done [6] = '{0, 0, 1, 0, 0, 0};
    clear_logs();
    bus.ifm_rdy = 1'b1;
    start_run(9'd5, 9'd0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (bus.ap_done !== exp_done[i] || bus.bram_en !== 1'b0 || bus.ifm_vld !== 1'b0) begin
        errors++;
        $display("FAIL zero[%0d] got done=%0b en=%0b vld=%0b want done=%0b en=0 vld=0", i, bus.ap_done, bus.bram_en, bus.ifm_vld, exp_done[i]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [4:0] outs;
    for (int j = 0; j < 4; j++) begin
      mem[j] = {8'(8'h83 + 4*j), 8'(8'h82 + 4*j), 8'(8'h81 + 4*j), 8'(8'h80 + 4*j)};
    end
    clear_logs();
    bus.ifm_rdy = 1'b1;
    start_run(9'd4, 9'd1);
    for (int c = 0; c < 50 && xq.size() < 5; c++) @(negedge clk);
    rst = 1'b1;
    #1;
    outs = {bus.bram_en, bus.ifm_vld, bus.ap_done, |bus.bram_addr, |bus.ifm_data};
    checks++;
    if (xq.size() != 5 || outs !== 5'b00000) begin
      errors++;
      $display("FAIL midrst_outputs got xfers=%0d outs=%05b want xfers=5 outs=00000", xq.size(), outs);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    repeat (6) @(negedge clk);
    checks++;
    if (xq.size() != 0 || aq.size() != 0 || done_cnt != 0) begin
      errors++;
      $display("FAIL midrst_quiet got xfers=%0d reads=%0d done=%0d want 0 0 0", xq.size(), aq.size(), done_cnt);
    end
    start_run(9'd4, 9'd1);
    for (int c = 0; c < 200 && done_cnt == 0; c++) @(negedge clk);
    checks++;
    if (done_cnt != 1 || xq.size() != 16 || aq.size() != 4 || aq[0] != 0) begin
      errors++;
      $display("FAIL midrst_rerun got done=%0d xfers=%0d reads=%0d want 1 16 4", done_cnt, xq.size(), aq.size());
    end
    for (int i = 0; i < xq.size() && i < 16; i++) begin
      checks++;
      if (xq[i] !== 8'(8'h80 + i)) begin
        errors++;
        $display("FAIL midrst_elem[%0d] got %h want %h", i, xq[i], 8'(8'h80 + i));
      end
    end
  endtask

  task automatic test_ignore_start();
    mem[0] = 32'h04030201;
    mem[1] = 32'h08070605;
    mem[2] = 32'h000000AA;
    clear_logs();
    bus.ifm_rdy = 1'b1;
    start_run(9'd3, 9'd1);
    repeat (3) @(negedge clk);
    bus.ifm_w    = 9'd4;
    bus.in_ch    = 9'd2;
    bus.ap_start = 1'b1;
    @(negedge clk);
    bus.ap_start = 1'b0;
    for (int c = 0; c < 200 && done_cnt == 0; c++) @(negedge clk);
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt != 1 || xq.size() != 9 || aq.size() != 3) begin
      errors++;
      $display("FAIL ignore_start got done=%0d xfers=%0d reads=%0d want 1 9 3", done_cnt, xq.size(), aq.size());
    end
    checks++;
    if (xq.size() == 9 && (xq[7] !== 8'h08 || xq[8] !== 8'hAA)) begin
      errors++;
      $display("FAIL ignore_tail got %h %h want 08 aa", xq[7], xq[8]);
    end
  endtask

  task automatic test_back_to_back();
    mem[0] = 32'h44332211;
    clear_logs();
    bus.ifm_rdy = 1'b1;
    start_run(9'd2, 9'd1);
    for (int c = 0; c < 50 && bus.ap_done !== 1'b1; c++) @(negedge clk);
    @(negedge clk);
    bus.ap_start = 1'b1;
    @(negedge clk);
    bus.ap_start = 1'b0;
    for (int c = 0; c < 50 && done_cnt < 2; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != 2 || xq.size() != 8 || aq.size() != 2) begin
      errors++;
      $display("FAIL b2b got done=%0d xfers=%0d reads=%0d want 2 8 2", done_cnt, xq.size(), aq.size());
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.ap_start = 1'b0;
    bus.ifm_w    = 9'd0;
    bus.in_ch    = 9'd0;
    bus.ifm_rdy  = 1'b0;
    for (int j = 0; j < 16; j++) mem[j] = 32'h0;
    clear_logs();
    repeat (3) @(negedge clk);
    test_reset();
    test_single_word();
    test_partial_word();
    test_backpressure();
    test_zero_size();
    test_reset_midrun();
    test_ignore_start();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
